vfd_capture: RTL and testbench

//   Downstream of the MCU output ports. Samples the multiplexed VFD drive (grid select from

---
 rtl/vfd_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_vfd_capture.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfd_capture.sv
// -----------------------------------------------------------------------------
// vfd_capture
//
// Rebuilds the VFD frame from the multiplexed grid/segment drive that the MCU
// puts on its output ports. The drive is sampled every clock. Once a sample has
// been stable for SETTLE clocks, the active grid's segment word is written into
// a per-grid frame buffer. Each buffered grid has a persistence counter: it
// blanks DECAY clocks after the grid was last captured, unless it is
// recaptured first. The renderer reads the buffer through a registered port.
//
// Ports
//   clk        system clock (shared with the MCU)
//   reset      asynchronous reset, active-high
//   grid_i     grid drive, bit n = grid n active (one-hot, 0 = blanking)
//   seg_i      segment drive for the active grid
//   rd_addr    frame buffer read index
//   rd_data    fb[rd_addr], one clock after rd_addr (0 for an index >= NGRID)
//   cap_stb    one-clock pulse: a grid was captured
//   cap_idx    index of the most recently captured grid
//   frame_stb  one-clock pulse: grid 0 captured after a higher-numbered grid
//   multi_err  one-clock pulse: a settled grid drive had more than one bit set
// -----------------------------------------------------------------------------
module vfd_capture #(
    parameter int NGRID   = 8,
    parameter int NSEG    = 16,
    parameter int SETTLE  = 4,
    parameter int DECAY_W = 8,
    parameter int DECAY   = 200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NGRID-1:0]         grid_i,
    input  logic [NSEG-1:0]          seg_i,
    input  logic [$clog2(NGRID)-1:0] rd_addr,
    output logic [NSEG-1:0]          rd_data,
    output logic                     cap_stb,
    output logic [$clog2(NGRID)-1:0] cap_idx,
    output logic                     frame_stb,
    output logic                     multi_err
);

    localparam int IDX_W = $clog2(NGRID);
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int SW    = NGRID + NSEG;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SW-1:0]    s_q, s_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    state_t           state_q, state_d;
    logic [NSEG-1:0]  rd_data_q, rd_data_d;
    logic             cap_stb_q, cap_stb_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic             frame_stb_q, frame_stb_d;
    logic             multi_err_q, multi_err_d;

    // Frame buffer contents gathered from the per-grid slices below.
    logic [NGRID-1:0][NSEG-1:0] fb_all;

    // ------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------
    logic [NGRID-1:0] grid_w;
    logic [NSEG-1:0]  seg_w;
    logic             changed;
    logic             grid_any;
    logic             grid_multi;
    logic [IDX_W-1:0] grid_idx;
    logic             settle_evt;
    logic             cap_we;

    assign s_d     = {grid_i, seg_i};
    assign grid_w  = s_q[SW-1:NSEG];
    assign seg_w   = s_q[NSEG-1:0];
    assign changed = (s_d != s_q);

    // x & (x-1) clears the lowest set bit; anything left means two or more bits.
    assign grid_any   = |grid_w;
    assign grid_multi = (grid_w & (grid_w - NGRID'(1))) != '0;

    always_comb begin
        grid_idx = '0;
        for (int i = 0; i < NGRID; i++) begin
            if (grid_w[i]) begin
                grid_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stability counter: restarts whenever the sample register takes a
    // new value, otherwise counts up and parks at SETTLE.
    // ------------------------------------------------------------------
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (changed) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_W'(SETTLE)) begin
            stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Settle FSM. The settle event is the edge on which the counter steps
    // from SETTLE-1 to SETTLE; HELD then blocks further events until the
    // drive moves again.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        settle_evt = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (!changed && stab_cnt_q == CNT_W'(SETTLE - 1)) begin
                    settle_evt = 1'b1;
                    state_d    = ST_HELD;
                end
            end
            ST_HELD: begin
                if (changed) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Blanking (no grid) settles silently; a multi-grid drive is flagged
    // and never written.
    assign cap_we = settle_evt && grid_any && !grid_multi;

    // ------------------------------------------------------------------
    // Strobes and capture index. cap_idx_q doubles as the previous
    // captured index used for frame-wrap detection, since both update on
    // every capture and nothing else.
    // ------------------------------------------------------------------
    always_comb begin
        cap_stb_d   = cap_we;
        multi_err_d = settle_evt && grid_multi;
        frame_stb_d = cap_we && (grid_idx == '0) && (cap_idx_q != '0);
        cap_idx_d   = cap_we ? grid_idx : cap_idx_q;
    end

    // ------------------------------------------------------------------
    // Read port. Reads the current (pre-write) contents, so a same-edge
    // write to the addressed grid shows up one clock later.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NGRID; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_data_d = fb_all[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-grid frame buffer word and persistence counter
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NGRID; gi++) begin : g_grid
            logic [NSEG-1:0]    fb_q, fb_d;
            logic [DECAY_W-1:0] decay_q, decay_d;

            always_comb begin
                fb_d    = fb_q;
                decay_d = decay_q;
                if (cap_we && grid_idx == IDX_W'(gi)) begin
                    // A capture reloads the counter even if it was about to expire.
                    fb_d = seg_w;
                    if (DECAY != 0) begin
                        decay_d = DECAY_W'(DECAY);
                    end
                end else if (decay_q != '0) begin
                    decay_d = decay_q - DECAY_W'(1);
                    if (decay_q == DECAY_W'(1)) begin
                        fb_d = '0;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    fb_q    <= '0;
                    decay_q <= '0;
                end else begin
                    fb_q    <= fb_d;
                    decay_q <= decay_d;
                end
            end

            assign fb_all[gi] = fb_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q         <= '0;
            stab_cnt_q  <= '0;
            state_q     <= ST_WAIT;
            rd_data_q   <= '0;
            cap_stb_q   <= 1'b0;
            cap_idx_q   <= '0;
            frame_stb_q <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            stab_cnt_q  <= stab_cnt_d;
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            cap_stb_q   <= cap_stb_d;
            cap_idx_q   <= cap_idx_d;
            frame_stb_q <= frame_stb_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign cap_stb   = cap_stb_q;
    assign cap_idx   = cap_idx_q;
    assign frame_stb = frame_stb_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_vfd_capture.sv
// -----------------------------------------------------------------------------
// tb_vfd_capture
//
// Directed stimulus for vfd_capture (NGRID=8, NSEG=16, SETTLE=4, DECAY=200).
// Stimulus pushes the expected strobe events (with the exact cycle they must
// appear) and the expected read results into queues; a monitor on the falling
// edge pops and compares whenever the DUT shows a strobe or a read completes.
// -----------------------------------------------------------------------------
module tb_vfd_capture;

    localparam int NGRID   = 8;
    localparam int NSEG    = 16;
    localparam int SETTLE  = 4;
    localparam int DECAY_W = 8;
    localparam int DECAY   = 200;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NGRID-1:0]  grid_i = '0;
    logic [NSEG-1:0]   seg_i = '0;
    logic [2:0]        rd_addr = '0;
    logic [NSEG-1:0]   rd_data;
    logic              cap_stb;
    logic [2:0]        cap_idx;
    logic              frame_stb;
    logic              multi_err;

    vfd_capture #(
        .NGRID  (NGRID),
        .NSEG   (NSEG),
        .SETTLE (SETTLE),
        .DECAY_W(DECAY_W),
        .DECAY  (DECAY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .grid_i   (grid_i),
        .seg_i    (seg_i),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cap_stb  (cap_stb),
        .cap_idx  (cap_idx),
        .frame_stb(frame_stb),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; stable at every falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         is_multi;
        logic [2:0] idx;
        bit         frame;
        int         cyc;
    } ev_t;

    ev_t             evq[$];
    logic [NSEG-1:0] rdq[$];
    logic            rd_req = 1'b0;
    logic            rd_pend = 1'b0;

    always @(posedge clk) rd_pend <= rd_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [NGRID-1:0] g, input logic [NSEG-1:0] s);
        grid_i = g;
        seg_i  = s;
    endtask

    // Called at the falling edge where the new drive is applied: the sample
    // register loads it on the next rising edge and the capture happens
    // SETTLE edges after that.
    task automatic expect_cap(input logic [2:0] idx, input bit frame);
        ev_t e;
        e.is_multi = 1'b0;
        e.idx      = idx;
        e.frame    = frame;
        e.cyc      = cyc + 1 + SETTLE;
        evq.push_back(e);
    endtask

    task automatic expect_multi(input logic [2:0] held_idx);
        ev_t e;
        e.is_multi = 1'b1;
        e.idx      = held_idx;
        e.frame    = 1'b0;
        e.cyc      = cyc + 1 + SETTLE;
        evq.push_back(e);
    endtask

    task automatic rd_once(input logic [2:0] addr, input logic [NSEG-1:0] exp);
        rd_addr = addr;
        rd_req  = 1'b1;
        rdq.push_back(exp);
        tick(1);
        rd_req  = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_data"},   32'(rd_data),   32'd0);
        chk({tag, "_cap_stb"},   32'(cap_stb),   32'd0);
        chk({tag, "_cap_idx"},   32'(cap_idx),   32'd0);
        chk({tag, "_frame_stb"}, 32'(frame_stb), 32'd0);
        chk({tag, "_multi_err"}, 32'(multi_err), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            if (cap_stb || multi_err) begin
                $display("cyc=%0d strobe cap=%b multi=%b idx=%0d frame=%b",
                         cyc, cap_stb, multi_err, cap_idx, frame_stb);
                if (evq.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, cap_stb, multi_err}, 32'd0);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("strobe_cycle", 32'(cyc),       32'(e.cyc));
                    chk("cap_stb",      32'(cap_stb),   32'(!e.is_multi));
                    chk("multi_err",    32'(multi_err), 32'(e.is_multi));
                    chk("cap_idx",      32'(cap_idx),   32'(e.idx));
                    chk("frame_stb",    32'(frame_stb), 32'(e.frame));
                end
            end else if (frame_stb) begin
                chk("stray_frame_stb", 32'(frame_stb), 32'd0);
            end
            if (rd_pend) begin
                $display("cyc=%0d read data=0x%04h", cyc, rd_data);
                if (rdq.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    logic [NSEG-1:0] x;
                    x = rdq.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(x));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        tick(3);
        chk_outputs_zero("reset");
        reset = 1'b0;
        tick(8);

        // 1: grid 2 held 10 cycles; read across the capture edge shows old
        //    data first, then the new word.
        drive(8'h04, 16'h1234);
        expect_cap(3'd2, 1'b0);
        tick(4);
        rd_addr = 3'd2;
        rd_req  = 1'b1;
        rdq.push_back(16'h0000);
        tick(1);
        rdq.push_back(16'h1234);
        tick(1);
        rd_req = 1'b0;
        tick(4);

        // 2: segments toggle every 3 cycles, never settle
        drive(8'h02, 16'h00FF);
        for (int k = 0; k < 10; k++) begin
            seg_i = k[0] ? 16'hFF00 : 16'h00FF;
            tick(3);
        end
        drive(8'h00, 16'h0000);
        rd_once(3'd1, 16'h0000);
        tick(6);

        // 3: two grids at once -> multi_err, buffer untouched
        drive(8'h05, 16'hCAFE);
        expect_multi(3'd2);
        tick(8);
        drive(8'h00, 16'h0000);
        rd_once(3'd0, 16'h0000);
        rd_once(3'd2, 16'h1234);
        tick(6);

        // 4a: capture grid 1 then blank; expires exactly DECAY edges later
        drive(8'h02, 16'hBEEF);
        expect_cap(3'd1, 1'b0);
        tick(6);
        drive(8'h00, 16'h0000);
        rd_once(3'd1, 16'hBEEF);
        tick(197);
        rd_addr = 3'd1;
        rd_req  = 1'b1;
        rdq.push_back(16'hBEEF);     // fb after capture+199
        tick(1);
        rdq.push_back(16'h0000);     // fb after capture+200
        tick(1);
        rd_req = 1'b0;
        tick(6);

        // 4b: recapture at capture+150 keeps the data past capture+200
        drive(8'h02, 16'hBEEF);
        expect_cap(3'd1, 1'b0);
        tick(6);
        drive(8'h00, 16'h0000);
        tick(144);
        drive(8'h02, 16'hBEEF);
        expect_cap(3'd1, 1'b0);
        tick(6);
        drive(8'h00, 16'h0000);
        tick(49);
        rd_once(3'd1, 16'hBEEF);     // fb after first capture+200
        tick(148);
        rd_addr = 3'd1;
        rd_req  = 1'b1;
        rdq.push_back(16'hBEEF);     // fb after recapture+199
        tick(1);
        rdq.push_back(16'h0000);     // fb after recapture+200
        tick(1);
        rd_req = 1'b0;
        tick(4);

        // 5: fresh reset, scan 0..7 then 0 again -> frame only on the wrap
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(8);
        for (int i = 0; i < NGRID; i++) begin
            drive(NGRID'(1) << i, 16'h0A00 + 16'(i));
            expect_cap(3'(i), 1'b0);
            tick(6);
        end
        drive(8'h01, 16'h0B00);
        expect_cap(3'd0, 1'b1);
        tick(6);
        rd_once(3'd5, 16'h0A05);
        rd_once(3'd0, 16'h0B00);

        // 6: reset while grid 3 is HELD, release with the drive unchanged
        drive(8'h08, 16'h5A5A);
        expect_cap(3'd3, 1'b0);
        tick(7);
        reset = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        tick(2);
        reset = 1'b0;
        expect_cap(3'd3, 1'b0);      // full SETTLE again after release
        rd_addr = 3'd3;
        rd_req  = 1'b1;
        rdq.push_back(16'h0000);
        tick(1);
        rd_addr = 3'd0;
        rdq.push_back(16'h0000);
        tick(1);
        rd_addr = 3'd1;
        rdq.push_back(16'h0000);
        tick(1);
        rd_req = 1'b0;
        tick(8);
        drive(8'h00, 16'h0000);
        tick(10);

        for (int i = 0; i < 20 && (evq.size() != 0 || rdq.size() != 0); i++) begin
            tick(1);
        end
        chk("pending_strobes", 32'(evq.size()), 32'd0);
        chk("pending_reads",   32'(rdq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
